hex_display_ctrl: RTL and testbench
===================================

# hex_display_ctrl

- Parametrised 7-segment display controller for the board's HEX digits; generalises the fixed-width display path.
- Shows one value across `NUM_DIGITS` digits, in hexadecimal (single-cycle) or decimal mode.
- Decimal mode uses a sequential binary-to-BCD (double-dabble) converter.
- Adds leading-zero blanking, overflow indication and optional per-digit blinking.
- Sits between the datapath/status registers and the board's active-low segment pins.

## Interface
- `NUM_DIGITS`, 4, number of 7-segment digits driven (1–8)
- `DATA_W`, 12, width of `value` (1–32)
- `BLINK_DIV`, 25_000_000, blink half-period in `clk` cycles
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `load`  in  1  request to capture `value`; accepted only while `busy`=0
- `mode`  in  1  0 = hex, 1 = decimal; sampled with `load`
- `blank_lz`  in  1  1 = blank leading zero digits; sampled with `load`
- `value`  in  DATA_W  number to display; sampled with `load`
- `blink_mask`  in  NUM_DIGITS  per-digit blink enable; live, not sampled
- `busy`  out  1  decimal conversion in progress
- `done`  out  1  one-cycle pulse when `hex` takes a new value
- `ovf`  out  1  last decimal load did not fit in NUM_DIGITS digits
- `hex`  out  7*NUM_DIGITS  segments, active-low
  - digit i occupies bits [7i+6:7i]; bit order g..a
  - digit 0 is least significant

## Operation
- **Reset:** `hex` all ones (blank), `busy`=0, `done`=0, `ovf`=0, FSM in IDLE, blink phase 0.
- **FSM states:** IDLE, CONV.
- **Hex mode (`mode`=0):**
  - Digit i = `value`[4i+3:4i], zero-extended; digits beyond DATA_W read 0.
  - No CONV state; `ovf` is cleared.
- **Decimal mode (`mode`=1):**
  - IDLE→CONV on load; runs DATA_W shift cycles; on each, every BCD nibble ≥5 gets +3, then shift left by one.
  - CONV→IDLE on the last shift.
  - BCD register is 4*NUM_DIGITS wide.
- **Overflow:**
  - At load, `value` ≥ 10^NUM_DIGITS (elaboration-time constant) sets `ovf`.
  - The conversion still runs for uniform latency.
  - The final `hex` shows '-' (7'h3F) in every digit.
- **Leading-zero blanking (`blank_lz`=1):**
  - Every digit above the most significant nonzero digit is blanked (7'h7F).
  - Digit 0 is never blanked.
  - Has no effect on the overflow pattern.
- **Glyphs:** standard 0–F; active-low, bit 0 = segment a.
- **Load while `busy`=1:** ignored, with no effect on the running conversion.
- **Reset asserted mid-conversion:** aborts immediately; outputs take their reset values.

## Timing
- **Hex mode:** `load` sampled high at edge k → `hex` updated at edge k, `done` high for the cycle after k.
- **Decimal mode:**
  - `load` at edge k → `busy` high from edge k through edge k+DATA_W.
  - At edge k+DATA_W: `hex` updates, `done` pulses, `busy` falls.
  - Latency is exactly DATA_W cycles.
- **Back-to-back:** a new load is accepted in the cycle where `done`=1.
- **`hex` stability:** holds its previous value throughout CONV; no intermediate BCD values are visible.
- **Registered outputs:** `busy`, `done`, `ovf` and `hex` are all registered.
  - Blink gating is the exception: it is registered, but may change `hex` on any cycle.

## Configuration
- **Macro:** `HEXDISP_BLINK_EN`.
- **Defined:**
  - A counter wraps at BLINK_DIV-1 and toggles a blink phase bit.
  - While phase=1, digits with `blink_mask`[i]=1 are driven blank (7'h7F).
  - Blanking is applied in the output register, one cycle after the phase changes.
- **Undefined:** no counter is built; `blink_mask` is ignored; `hex` changes only on `done`.

## Structure
- **Package `hex_display_pkg`:**
  - 16-entry glyph table.
  - `SEG_BLANK` (7'h7F) and `SEG_DASH` (7'h3F).
  - State enum {IDLE, CONV}.
  - Function computing 10^n.
- **Sub-module `seg7_decode`:** combinational 4-bit → 7-segment, active-low; instantiated NUM_DIGITS times.

## Test plan
Bench uses NUM_DIGITS=4, DATA_W=12 unless noted.
1. Assert `rst_n`=0 mid-run → `hex`=28'hFFFFFFF, `busy`=0, `done`=0, `ovf`=0 immediately and throughout reset.
2. mode=0, value=12'h343, blank_lz=0 → digits 3..0 = 7'h40, 7'h30, 7'h19, 7'h30 one edge after load; `done` one cycle.
3. mode=1, value=12'h055 (85), blank_lz=1:
   - `busy` high 12 cycles.
   - Then digits 3..0 = 7'h7F, 7'h7F, 7'h00, 7'h12, with `done` pulse.
4. NUM_DIGITS=3, mode=1, value=12'd1000 → after 12 cycles `ovf`=1, all digits 7'h3F; value=12'd999 next → `ovf`=0, digits 7'h10, 7'h10, 7'h10.
5. Second load (12'h015) issued while `busy`=1 → ignored, first result displayed.
   - Then a load on the `done` cycle is accepted.
   - `rst_n` low at cycle 5 of CONV → blank, IDLE.
6. With `HEXDISP_BLINK_EN`, BLINK_DIV=4, blink_mask=4'b0001 → digit 0 alternates glyph/7'h7F every 4 cycles, other digits steady; without the macro, digit 0 stays steady.

Source files
------------

// File: rtl/hex_display_pkg.sv
// hex_display_pkg: shared types and constants for the 7-segment display controller.
// Latency: n/a (types, constants and a constant function only).
// Backpressure: n/a.
package hex_display_pkg;

    // Active-low glyphs, bit order g..a, for digits 0..F (index 15 is leftmost).
    localparam logic [15:0][6:0] GLYPH = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_e;

    // 10^n, used at elaboration time for the decimal overflow limit.
    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: one hex nibble to an active-low 7-segment glyph (bit order g..a).
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of the input nibble.
module seg7_decode
    import hex_display_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    assign seg_o = GLYPH[nib_i];

endmodule

// File: rtl/hex_display_ctrl.sv
// hex_display_ctrl: one value on NUM_DIGITS active-low digits, hex (direct) or decimal (double-dabble).
// Latency: hex load -> hex/done at the load edge; decimal load -> result exactly DATA_W cycles later.
// Backpressure: loads are dropped while busy; HEXDISP_BLINK_EN builds the per-digit blink gate.
module hex_display_ctrl
    import hex_display_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DATA_W     = 12,
    parameter int BLINK_DIV  = 25_000_000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic                    mode,
    input  logic                    blank_lz,
    input  logic [DATA_W-1:0]       value,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    output logic                    busy,
    output logic                    done,
    output logic                    ovf,
    output logic [7*NUM_DIGITS-1:0] hex
);

    localparam int          BCD_W     = 4 * NUM_DIGITS;
    localparam int          SEG_W     = 7 * NUM_DIGITS;
    localparam int          CNT_W     = $clog2(DATA_W + 1);
    localparam logic [63:0] OVF_LIMIT = pow10(NUM_DIGITS);

    state_e             state_q, state_d;
    logic [DATA_W-1:0]  bin_q, bin_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d, bcd_adj;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               blz_q, blz_d;
    logic               ovf_q, ovf_d;
    logic               done_q, done_d;
    logic [SEG_W-1:0]   disp_q, disp_d, disp_new;
    logic [BCD_W-1:0]   nib;
    logic [SEG_W-1:0]   seg_raw;
    logic               upd, use_bcd, blz_sel, lead;

    // Control FSM: accepts loads in IDLE, runs one add-3/shift step per CONV cycle, publishes on the last.
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        blz_d   = blz_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        upd     = 1'b0;
        use_bcd = 1'b0;
        bcd_adj = bcd_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_adj[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_adj[4*i +: 4] + 4'd3;
            end
        end
        case (state_q)
            IDLE: begin
                if (load) begin
                    if (mode) begin
                        // First shift is folded into the load: BCD starts at zero, so no adjust is needed.
                        state_d = CONV;
                        bin_d   = value << 1;
                        bcd_d   = BCD_W'(value[DATA_W-1]);
                        cnt_d   = CNT_W'(1);
                        blz_d   = blank_lz;
                        ovf_d   = (64'(value) >= OVF_LIMIT);
                    end else begin
                        upd    = 1'b1;
                        ovf_d  = 1'b0;
                        done_d = 1'b1;
                    end
                end
            end
            CONV: begin
                if (cnt_q == CNT_W'(DATA_W)) begin
                    state_d = IDLE;
                    upd     = 1'b1;
                    use_bcd = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    bcd_d = (bcd_adj << 1) | BCD_W'(bin_q[DATA_W-1]);
                    bin_d = bin_q << 1;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign nib     = use_bcd ? bcd_q : BCD_W'(value);
    assign blz_sel = use_bcd ? blz_q : blank_lz;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
        seg7_decode u_dec (
            .nib_i (nib[4*g +: 4]),
            .seg_o (seg_raw[7*g +: 7])
        );
    end

    // Display formatting: overflow dashes win, then leading-zero blanking (digit 0 always shown).
    always_comb begin
        disp_new = '1;
        lead     = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (nib[4*i +: 4] != 4'd0) begin
                lead = 1'b0;
            end
            if (use_bcd && ovf_q) begin
                disp_new[7*i +: 7] = SEG_DASH;
            end else if (blz_sel && lead && (i != 0)) begin
                disp_new[7*i +: 7] = SEG_BLANK;
            end else begin
                disp_new[7*i +: 7] = seg_raw[7*i +: 7];
            end
        end
        disp_d = upd ? disp_new : disp_q;
    end

    // State and datapath registers; reset aborts any conversion and blanks the display.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            blz_q   <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            disp_q  <= '1;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            blz_q   <= blz_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            disp_q  <= disp_d;
        end
    end

    assign busy = (state_q == CONV);
    assign done = done_q;
    assign ovf  = ovf_q;

`ifdef HEXDISP_BLINK_EN
    localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [BLK_W-1:0] blk_cnt_q, blk_cnt_d;
    logic             blk_phase_q, blk_phase_d;
    logic [SEG_W-1:0] hex_q, hex_d;

    // Blink timebase and output gate: masked digits go blank while the phase bit is set.
    always_comb begin
        blk_cnt_d   = blk_cnt_q + 1'b1;
        blk_phase_d = blk_phase_q;
        if (blk_cnt_q == BLK_W'(BLINK_DIV - 1)) begin
            blk_cnt_d   = '0;
            blk_phase_d = ~blk_phase_q;
        end
        hex_d = disp_d;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (blk_phase_q && blink_mask[i]) begin
                hex_d[7*i +: 7] = SEG_BLANK;
            end
        end
    end

    // Blink counter, phase and gated output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_cnt_q   <= '0;
            blk_phase_q <= 1'b0;
            hex_q       <= '1;
        end else begin
            blk_cnt_q   <= blk_cnt_d;
            blk_phase_q <= blk_phase_d;
            hex_q       <= hex_d;
        end
    end

    assign hex = hex_q;
`else
    logic unused_blink;
    assign unused_blink = (^blink_mask) ^ (BLINK_DIV > 0);
    assign hex = disp_q;
`endif

endmodule

// File: tb/tb_hex_display_ctrl.sv
// tb_hex_display_ctrl: drives a 4-digit and a 3-digit controller from shared inputs.
// Latency: checks hex/decimal timing, overflow, blanking, ignored loads and reset abort.
// Backpressure: loads issued while busy must be dropped; loads on the done cycle accepted.
module tb_hex_display_ctrl;

    localparam int DW = 12;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic        mode;
    logic        blank_lz;
    logic [11:0] value;
    logic [3:0]  mask4;
    logic [2:0]  mask3;
    logic        busy4, done4, ovf4;
    logic        busy3, done3, ovf3;
    logic [27:0] hex4;
    logic [20:0] hex3;

    logic [27:0] cur4;
    logic [20:0] cur3;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    hex_display_ctrl #(.NUM_DIGITS(4), .DATA_W(DW), .BLINK_DIV(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .load(load), .mode(mode), .blank_lz(blank_lz),
        .value(value), .blink_mask(mask4), .busy(busy4), .done(done4), .ovf(ovf4), .hex(hex4)
    );

    hex_display_ctrl #(.NUM_DIGITS(3), .DATA_W(DW), .BLINK_DIV(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .load(load), .mode(mode), .blank_lz(blank_lz),
        .value(value), .blink_mask(mask3), .busy(busy3), .done(done3), .ovf(ovf3), .hex(hex3)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] glyph(input int d);
        case (d)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10;  10: return 7'h08; 11: return 7'h03;
            12: return 7'h46; 13: return 7'h21; 14: return 7'h06; default: return 7'h0E;
        endcase
    endfunction

    function automatic int unsigned pw10(input int n);
        int unsigned p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    // Reference display: digits by arithmetic (divide/mod or nibble extraction), then rules.
    function automatic logic [55:0] model(input int ndig, input bit md, input bit blz, input int unsigned v);
        logic [55:0] r;
        int          d [8];
        int          msd;
        bit          ov;
        r   = '1;
        msd = 0;
        ov  = md && (v >= pw10(ndig));
        for (int i = 0; i < ndig; i++) begin
            d[i] = md ? int'((v / pw10(i)) % 10) : int'((v >> (4 * i)) & 32'hF);
            if (d[i] != 0) msd = i;
        end
        for (int i = 0; i < ndig; i++) begin
            if (ov)                    r[7*i +: 7] = 7'h3F;
            else if (blz && i > msd)   r[7*i +: 7] = 7'h7F;
            else                       r[7*i +: 7] = glyph(d[i]);
        end
        return r;
    endfunction

    task automatic gap();
        step();
        check_eq("done4_fall", done4, 0);
        check_eq("done3_fall", done3, 0);
    endtask

    task automatic run_load(input bit md, input bit blz, input int unsigned v,
                            input int intrude, input int unsigned iv);
        logic [55:0] e4, e3;
        int          cycles;
        mode = md; blank_lz = blz; value = v[11:0]; load = 1'b1;
        step();
        load = 1'b0; value = 12'($urandom); mode = 1'($urandom); blank_lz = 1'($urandom);
        e4 = model(4, md, blz, v);
        e3 = model(3, md, blz, v);
        if (!md) begin
            check_eq("hex4_hexmode", hex4, e4[27:0]);
            check_eq("hex3_hexmode", hex3, e3[20:0]);
            check_eq("done4_hexmode", done4, 1);
            check_eq("busy4_hexmode", busy4, 0);
            check_eq("ovf4_hexmode", ovf4, 0);
            check_eq("ovf3_hexmode", ovf3, 0);
        end else begin
            cycles = 0;
            while (busy4 && cycles < 40) begin
                check_eq("hold4", hex4, cur4);
                check_eq("hold3", hex3, cur3);
                check_eq("busy3_conv", busy3, 1);
                check_eq("done4_conv", done4, 0);
                if (intrude != 0 && cycles == intrude) begin
                    load = 1'b1; value = iv[11:0]; mode = 1'($urandom);
                end
                step();
                load = 1'b0;
                cycles++;
            end
            check_eq("latency", cycles, DW);
            check_eq("busy3_end", busy3, 0);
            check_eq("done4_dec", done4, 1);
            check_eq("done3_dec", done3, 1);
            check_eq("hex4_dec", hex4, e4[27:0]);
            check_eq("hex3_dec", hex3, e3[20:0]);
            check_eq("ovf4_dec", ovf4, 0);
            check_eq("ovf3_dec", ovf3, (v >= 1000) ? 1 : 0);
        end
        cur4 = e4[27:0];
        cur3 = e3[20:0];
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_hex4"}, hex4, 28'hFFFFFFF);
        check_eq({tag, "_hex3"}, hex3, 21'h1FFFFF);
        check_eq({tag, "_busy"}, {busy4, busy3}, 0);
        check_eq({tag, "_done"}, {done4, done3}, 0);
        check_eq({tag, "_ovf"}, {ovf4, ovf3}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1; load = 1'b0; mode = 1'b0; blank_lz = 1'b0; value = '0;
        mask4 = '0; mask3 = '0;
        cur4 = '1; cur3 = '1;
        #2 rst_n = 1'b0;
        #1 check_reset_state("por");
        step();
        step();
        check_reset_state("por_hold");
        rst_n = 1'b1;
        step();

        // Directed cases
        run_load(0, 0, 12'h343, 0, 0);
        gap();
        run_load(1, 1, 85, 0, 0);
        gap();
        run_load(1, 0, 1000, 0, 0);
        check_eq("ovf3_1000", ovf3, 1);
        run_load(1, 0, 999, 0, 0);
        gap();
        run_load(1, 0, 12'h0A7, 3, 12'h015);
        run_load(0, 1, 12'h015, 0, 0);
        gap();

        // Reset in the middle of a conversion that also raises ovf on the 3-digit unit
        mode = 1'b1; value = 12'd1234; blank_lz = 1'b0; load = 1'b1;
        step();
        load = 1'b0;
        check_eq("ovf3_pre_reset", ovf3, 1);
        repeat (4) step();
        rst_n = 1'b0;
        #1 check_reset_state("mid_rst");
        step();
        check_reset_state("mid_rst_hold");
        rst_n = 1'b1;
        cur4 = '1; cur3 = '1;
        step();
        check_reset_state("post_rst");
        run_load(1, 0, 321, 0, 0);

        // Randomized loads: mixed modes, gaps, back-to-back and ignored intruding loads
        for (int it = 0; it < 40; it++) begin
            int unsigned v;
            int          intr;
            v    = $urandom_range(0, 1) ? $urandom_range(0, 999) : $urandom_range(0, 4095);
            intr = $urandom_range(0, 1) ? $urandom_range(1, DW - 1) : 0;
            run_load(1'($urandom), 1'($urandom), v, intr, $urandom_range(0, 4095));
            if ($urandom_range(0, 1) == 1) gap();
        end

        // Blink behaviour on digit 0
        run_load(0, 0, 12'h5A7, 0, 0);
        mask4 = 4'b0001; mask3 = 3'b001;
`ifdef HEXDISP_BLINK_EN
        begin
            int          run;
            int          nruns;
            logic [6:0]  prev0;
            prev0 = hex4[6:0]; run = 0; nruns = 0;
            for (int c = 0; c < 40; c++) begin
                step();
                check_eq("blk_upper4", hex4[27:7], cur4[27:7]);
                check_eq("blk_upper3", hex3[20:7], cur3[20:7]);
                check_eq("blk_val", (hex4[6:0] == cur4[6:0]) || (hex4[6:0] == 7'h7F), 1);
                if (hex4[6:0] == prev0) begin
                    run++;
                end else begin
                    if (nruns > 0) check_eq("blk_run", run, 4);
                    nruns++;
                    run   = 1;
                    prev0 = hex4[6:0];
                end
            end
            check_eq("blk_toggles", (nruns >= 8) ? 1 : 0, 1);
        end
`else
        for (int c = 0; c < 24; c++) begin
            step();
            check_eq("steady4", hex4, cur4);
            check_eq("steady3", hex3, cur3);
        end
`endif
        mask4 = '0; mask3 = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
